// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries IF-stage predictions through ID/EX slots,
// resolves them in EX, redirects/flushes on mispredict, feeds the predictor
// update bus and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_target,
  input  logic             stall,
  input  logic             id_is_branch,
  input  logic             id_is_jump,
  input  logic             ex_cond_taken,
  input  logic [31:0]      ex_target,
  output logic             is_incorrect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [31:0]      upd_addr,
  output logic [31:0]      upd_target,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
  } id_slot_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        br;
    logic        jmp;
  } ex_slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  id_slot_t    id_q;
  ex_slot_t    ex_q;
  logic        ctl;
  logic        act_taken;
  logic        mispredict;
  logic [31:0] act_next;

  // Resolve the EX slot against the real outcome; nothing fires on an empty slot.
  always_comb begin
    ctl        = ex_q.br | ex_q.jmp;
    act_taken  = ex_q.jmp | (ex_q.br & ex_cond_taken);
    act_next   = act_taken ? ex_target : ex_q.pc + 32'd4;
    mispredict = 1'b0;
    if (ex_q.v) begin
      if (ctl)
        mispredict = (ex_q.pt != act_taken) |
                     (act_taken & ex_q.pt & (ex_q.ptgt != ex_target));
      else
        mispredict = ex_q.pt;  // BTB aliased onto a non-branch
    end
  end

  assign is_incorrect = mispredict;
  assign flush_if_id  = mispredict;
  assign flush_id_ex  = mispredict;
  assign redirect_pc  = mispredict ? act_next : 32'd0;
  assign upd_valid    = ex_q.v & ctl;
  assign upd_taken    = ex_q.v & act_taken;
  assign upd_addr     = ex_q.v ? ex_q.pc : 32'd0;
  assign upd_target   = (ex_q.v & act_taken) ? ex_target : 32'd0;

  // Slot advance: a mispredict squashes both slots even under stall; a stall
  // holds ID and bubbles EX so the held instruction enters EX exactly once.
  always_ff @(posedge clk) begin
    if (reset || mispredict) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= '0;
    end else begin
      id_q <= '{v: if_valid, pc: if_pc, pt: if_pred_taken, ptgt: if_pred_target};
      ex_q <= '{v: id_q.v, pc: id_q.pc, pt: id_q.pt, ptgt: id_q.ptgt,
                br: id_is_branch, jmp: id_is_jump};
    end
  end

  // Saturating perf counters, stepped once per resolved instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ex_q.v) begin
      if (ctl && stat_branches != CNT_MAX)
        stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && stat_mispredicts != CNT_MAX)
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule
